acc_cpu_core: RTL and testbench
===============================

Name: acc_cpu_core

Overview:
- Parametrised multi-cycle accumulator CPU core, the successor to the fixed 8-bit/16-word design.
- Sequences fetch, decode, optional indirect and execute through an explicit FSM.
- Drives an external synchronous single-port memory with 1-cycle read latency.
- Adds reset, carry/zero flags, load/store, jump and halt. Top-level integration instantiates it beside the memory block.

Parameters:
- DATA_W, 8: word width of AC, IR and memory data; must be >= ADDR_W+4.
- ADDR_W, 4: address width of PC, AR and memory; memory depth is 2**ADDR_W.
- RESET_PC, 0: PC value after reset.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset (see Behaviour).
- mem_addr  out  ADDR_W  memory address: PC in S_FETCH, AR in all other states.
- mem_wdata  out  DATA_W  equals AC.
- mem_we  out  1  write strobe.
- mem_rdata  in  DATA_W  read data, valid the cycle after mem_addr is presented.
- ac  out  DATA_W  accumulator.
- pc  out  ADDR_W  program counter.
- e_flag  out  1  carry/borrow flag.
- z_flag  out  1  set when AC==0.
- halted  out  1  core is in S_HALT.
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction.

Behaviour:
- Clock and reset: one clock, CLK; RST is synchronous, active-high, and overrides everything.
- Reset values: PC=RESET_PC, AR=0, IR=0, AC=0, e_flag=0, z_flag=1, halted=0, state=S_FETCH.
- RST in the same cycle as an S_EXEC STA forces mem_we=0, so no write occurs.
- IR fields:
  - I = IR[DATA_W-1].
  - op = IR[DATA_W-2:DATA_W-4].
  - addr = IR[ADDR_W-1:0].
  - Unused middle bits are ignored.
- Opcodes:
  - 000 ADD: AC+M; E=carry out.
  - 001 SUB: AC-M mod 2**DATA_W; E=1 iff AC<M (borrow).
  - 010 XOR: AC^M.
  - 011 SHL: AC+AC; E=old AC MSB.
  - 100 LDA: AC=M.
  - 101 STA: M=AC.
  - 110 CMA: ~AC.
  - 111 with I=0 JMP: PC=addr. 111 with I=1 HLT.
  - E is unchanged by every opcode not listed as setting it. Z is updated whenever AC is written.
- FSM:
  - S_FETCH: mem_addr=PC. Next S_LOADIR.
  - S_LOADIR: IR<=mem_rdata; PC<=PC+1, wrapping modulo 2**ADDR_W. Next S_DECODE.
  - S_DECODE: AR<=addr.
    - SHL/CMA go to S_EXEC.
    - JMP sets PC<=addr, pulses instr_done and goes to S_FETCH.
    - HLT goes to S_HALT.
    - Otherwise, I=1 goes to S_IND_RD; STA with I=0 goes to S_EXEC; all others go to S_OP_RD.
  - S_IND_RD: mem_addr=AR. Next S_IND_LD.
  - S_IND_LD: AR<=mem_rdata[ADDR_W-1:0]. STA goes to S_EXEC; others go to S_OP_RD.
  - S_OP_RD: mem_addr=AR. Next S_EXEC.
  - S_EXEC: DR=mem_rdata; ALU result written to AC/E/Z. STA drives mem_we=1 at AR for exactly this cycle. Pulses instr_done, then goes to S_FETCH.
  - S_HALT: holds all registers, mem_we=0, halted=1; leaves only on RST.
- Latency in cycles:
  - JMP: 3.
  - SHL, CMA and direct STA: 4.
  - Direct ADD/SUB/XOR/LDA: 5.
  - Indirect adds 2.
  - HLT reaches halted=1 three cycles after S_FETCH.
- mem_we is 0 in every state except S_EXEC with op=STA.

Decomposition:
- Package acc_cpu_pkg holds:
  - opcode localparams OP_ADD..OP_JMP;
  - state encoding S_FETCH..S_HALT;
  - field-position functions taking DATA_W/ADDR_W.
- Sub-module acc_cpu_alu (combinational, parametrised DATA_W):
  - inputs: op, AC, DR, E_in;
  - outputs: result, E_out, we_ac.
  - The core holds the FSM and registers.

Test Plan:
- Reset: hold RST high 2 cycles mid-program -> pc=0, ac=0, z_flag=1, e_flag=0, halted=0, mem_we=0; next cycle mem_addr=0.
- Direct load and add: M[0]=0x48 (LDA 8), M[1]=0x09 (ADD 9), M[8]=0xF0, M[9]=0x20 -> instr_done on cycle 5 then cycle 10; final ac=0x10, e_flag=1, z_flag=0, pc=2.
- Indirect store: AC=0x3C, M[0]=0xDA (STA I, 10), M[10]=0x0C -> mem_we high exactly 1 cycle with mem_addr=0x0C and mem_wdata=0x3C, 6 cycles after fetch; RST asserted in that exact cycle instead -> no write.
- Subtract with borrow: AC=0x03, SUB from M=0x05 -> ac=0xFE, e_flag=1, z_flag=0. Then SUB from M=0xFE -> ac=0x00, e_flag=0, z_flag=1.
- PC wrap and halt: M[15]=0xF0 (HLT) with PC reaching 15 -> pc wraps to 0 in S_LOADIR; halted=1; pc, ac and mem_we stay frozen for 20 cycles; RST then resumes fetching at address 0.
- Parametrised instance: DATA_W=12, ADDR_W=8, M[0]=0x7C8 (JMP 0xC8) -> pc=0xC8 after 3 cycles and next mem_addr=0xC8.

Source files
------------

// File: rtl/acc_cpu_pkg.sv
// Shared definitions for the accumulator CPU core.
//   - Opcode encodings (3-bit op field of the instruction register).
//   - FSM state encoding used by acc_cpu_core.
//   - Field-position helpers: instruction fields are placed relative to the
//     top of the data word, so their bit positions depend on DATA_W / ADDR_W.
package acc_cpu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_SHL = 3'b011;
    localparam logic [2:0] OP_LDA = 3'b100;
    localparam logic [2:0] OP_STA = 3'b101;
    localparam logic [2:0] OP_CMA = 3'b110;
    localparam logic [2:0] OP_JMP = 3'b111;  // with I=1 this encoding is HLT

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_LOADIR = 3'd1,
        S_DECODE = 3'd2,
        S_IND_RD = 3'd3,
        S_IND_LD = 3'd4,
        S_OP_RD  = 3'd5,
        S_EXEC   = 3'd6,
        S_HALT   = 3'd7
    } state_t;

    // Indirect-addressing bit: the MSB of the instruction word.
    function automatic int fld_ind(input int data_w);
        return data_w - 1;
    endfunction

    // Opcode occupies the three bits just below the indirect bit.
    function automatic int fld_op_msb(input int data_w);
        return data_w - 2;
    endfunction

    function automatic int fld_op_lsb(input int data_w);
        return data_w - 4;
    endfunction

    // Address field sits at the bottom of the word.
    function automatic int fld_addr_msb(input int addr_w);
        return addr_w - 1;
    endfunction

endpackage

// File: rtl/acc_cpu_alu.sv
// Combinational ALU for the accumulator CPU.
//   op     : opcode from the instruction register
//   ac     : current accumulator
//   dr     : operand read from memory
//   e_in   : current carry/borrow flag
//   result : new accumulator value (valid when we_ac=1)
//   e_out  : new carry/borrow flag (equals e_in for ops that leave it alone)
//   we_ac  : 1 when the opcode writes the accumulator
module acc_cpu_alu
    import acc_cpu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] ac,
    input  logic [DATA_W-1:0] dr,
    input  logic              e_in,
    output logic [DATA_W-1:0] result,
    output logic              e_out,
    output logic              we_ac
);

    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;

    // One extra bit captures carry out of the add and borrow out of the subtract.
    assign sum  = {1'b0, ac} + {1'b0, dr};
    assign diff = {1'b0, ac} - {1'b0, dr};

    always_comb begin
        result = ac;
        e_out  = e_in;
        we_ac  = 1'b1;
        case (op)
            OP_ADD: begin
                result = sum[DATA_W-1:0];
                e_out  = sum[DATA_W];
            end
            OP_SUB: begin
                result = diff[DATA_W-1:0];
                e_out  = diff[DATA_W];
            end
            OP_XOR: result = ac ^ dr;
            OP_SHL: begin
                result = {ac[DATA_W-2:0], 1'b0};
                e_out  = ac[DATA_W-1];
            end
            OP_LDA: result = dr;
            OP_CMA: result = ~ac;
            default: we_ac = 1'b0;  // STA and JMP/HLT leave AC untouched
        endcase
    end

endmodule

// File: rtl/acc_cpu_core.sv
// Multi-cycle accumulator CPU core driving an external synchronous
// single-port memory with one cycle of read latency.
//   CLK, RST    : clock, synchronous active-high reset
//   mem_addr    : PC during fetch, AR otherwise
//   mem_wdata   : always the accumulator
//   mem_we      : write strobe, only in S_EXEC of a STA
//   mem_rdata   : read data, valid the cycle after mem_addr
//   ac, pc      : accumulator and program counter
//   e_flag      : carry/borrow flag
//   z_flag      : AC==0 flag
//   halted      : core is parked in S_HALT
//   instr_done  : single-cycle pulse on the last cycle of each instruction
// The FSM register is the signal 'state' (type state_t) for observation.
module acc_cpu_core
    import acc_cpu_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 4,
    parameter int RESET_PC = 0
) (
    input  logic              CLK,
    input  logic              RST,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] ac,
    output logic [ADDR_W-1:0] pc,
    output logic              e_flag,
    output logic              z_flag,
    output logic              halted,
    output logic              instr_done
);

    localparam int IND_BIT  = fld_ind(DATA_W);
    localparam int OP_MSB   = fld_op_msb(DATA_W);
    localparam int OP_LSB   = fld_op_lsb(DATA_W);
    localparam int ADDR_MSB = fld_addr_msb(ADDR_W);

    state_t state, state_nxt;

    // IR is kept as its decoded fields; the unused middle bits are never stored.
    logic              ir_ind;
    logic [2:0]        ir_op;
    logic [ADDR_W-1:0] ir_addr;

    logic [ADDR_W-1:0] pc_q, ar_q;
    logic [DATA_W-1:0] ac_q;
    logic              e_q, z_q;

    logic [DATA_W-1:0] alu_res;
    logic              alu_e, alu_we;

    acc_cpu_alu #(.DATA_W(DATA_W)) u_alu (
        .op     (ir_op),
        .ac     (ac_q),
        .dr     (mem_rdata),
        .e_in   (e_q),
        .result (alu_res),
        .e_out  (alu_e),
        .we_ac  (alu_we)
    );

    // Next state and per-state outputs.
    always_comb begin
        state_nxt  = state;
        mem_addr   = ar_q;
        mem_we     = 1'b0;
        instr_done = 1'b0;
        case (state)
            S_FETCH: begin
                mem_addr  = pc_q;
                state_nxt = S_LOADIR;
            end
            S_LOADIR: state_nxt = S_DECODE;
            S_DECODE: begin
                if (ir_op == OP_SHL || ir_op == OP_CMA) begin
                    state_nxt = S_EXEC;
                end else if (ir_op == OP_JMP) begin
                    if (ir_ind) begin
                        state_nxt = S_HALT;
                    end else begin
                        instr_done = 1'b1;
                        state_nxt  = S_FETCH;
                    end
                end else if (ir_ind) begin
                    state_nxt = S_IND_RD;
                end else if (ir_op == OP_STA) begin
                    state_nxt = S_EXEC;
                end else begin
                    state_nxt = S_OP_RD;
                end
            end
            S_IND_RD: state_nxt = S_IND_LD;
            S_IND_LD: state_nxt = (ir_op == OP_STA) ? S_EXEC : S_OP_RD;
            S_OP_RD:  state_nxt = S_EXEC;
            S_EXEC: begin
                // Reset in the store cycle must suppress the write.
                mem_we     = (ir_op == OP_STA) && !RST;
                instr_done = 1'b1;
                state_nxt  = S_FETCH;
            end
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= S_FETCH;
            pc_q    <= ADDR_W'(RESET_PC);
            ar_q    <= '0;
            ir_ind  <= 1'b0;
            ir_op   <= 3'b000;
            ir_addr <= '0;
            ac_q    <= '0;
            e_q     <= 1'b0;
            z_q     <= 1'b1;
        end else begin
            state <= state_nxt;
            case (state)
                S_LOADIR: begin
                    ir_ind  <= mem_rdata[IND_BIT];
                    ir_op   <= mem_rdata[OP_MSB:OP_LSB];
                    ir_addr <= mem_rdata[ADDR_MSB:0];
                    pc_q    <= pc_q + 1'b1;
                end
                S_DECODE: begin
                    ar_q <= ir_addr;
                    if (ir_op == OP_JMP && !ir_ind) pc_q <= ir_addr;
                end
                S_IND_LD: ar_q <= mem_rdata[ADDR_MSB:0];
                S_EXEC: begin
                    if (alu_we) begin
                        ac_q <= alu_res;
                        e_q  <= alu_e;
                        z_q  <= (alu_res == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_wdata = ac_q;
    assign ac        = ac_q;
    assign pc        = pc_q;
    assign e_flag    = e_q;
    assign z_flag    = z_q;
    assign halted    = (state == S_HALT);

endmodule

// File: tb/tb_acc_cpu_core.sv
// Bench for acc_cpu_core: an 8/4 instance and a 12/8 instance, each with its
// own synchronous memory model. Handshake: instructions have no valid/ready;
// completion is observed through the instr_done pulse, and all DUT outputs
// are sampled on the falling clock edge.
module tb_acc_cpu_core;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst, rst2;

    // ---------------- DUT A (DATA_W=8, ADDR_W=4) ----------------
    logic [3:0] mem_addr, pc;
    logic [7:0] mem_wdata, mem_rdata, ac;
    logic       mem_we, e_flag, z_flag, halted, instr_done;

    acc_cpu_core dut (
        .CLK(clk), .RST(rst), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_rdata(mem_rdata), .ac(ac), .pc(pc),
        .e_flag(e_flag), .z_flag(z_flag), .halted(halted), .instr_done(instr_done)
    );

    // ---------------- DUT B (DATA_W=12, ADDR_W=8) ----------------
    logic [7:0]  b_mem_addr, b_pc;
    logic [11:0] b_mem_wdata, b_mem_rdata, b_ac;
    logic        b_mem_we, b_e, b_z, b_halted, b_done;

    acc_cpu_core #(.DATA_W(12), .ADDR_W(8), .RESET_PC(0)) dut_b (
        .CLK(clk), .RST(rst2), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_we(b_mem_we), .mem_rdata(b_mem_rdata), .ac(b_ac), .pc(b_pc),
        .e_flag(b_e), .z_flag(b_z), .halted(b_halted), .instr_done(b_done)
    );

    // ---------------- memories ----------------
    logic [7:0]  mem[16];
    logic [11:0] mem_b[256];
    logic        load_en, load_sel;
    logic [7:0]  load_addr;
    logic [11:0] load_data;

    always @(posedge clk) begin
        if (load_en && !load_sel) mem[load_addr[3:0]] <= load_data[7:0];
        else if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    always @(posedge clk) begin
        if (load_en && load_sel) mem_b[load_addr] <= load_data;
        else if (b_mem_we) mem_b[b_mem_addr] <= b_mem_wdata;
        b_mem_rdata <= mem_b[b_mem_addr];
    end

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [13:0] exp_q[$];   // {pc, e, z, ac} after each instruction
    int          lat_q[$];   // cycles per instruction
    logic [7:0]  img[16];
    logic [7:0]  mdl_mem[16];
    logic        mdl_halt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic load_word(input logic sel, input logic [7:0] a, input logic [11:0] d);
        load_en = 1'b1; load_sel = sel; load_addr = a; load_data = d;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    // Hold reset while the image is written, then release in the fetch cycle.
    task automatic start_prog();
        rst = 1'b1;
        for (int i = 0; i < 16; i++) load_word(1'b0, 8'(i), {4'h0, img[i]});
        rst = 1'b0;
    endtask

    task automatic clear_img();
        foreach (img[i]) img[i] = 8'h00;
    endtask

    // Entered at the falling edge of a fetch cycle (cycle 1); returns the
    // cycle number on which instr_done was seen (0 if never), then steps to
    // the next fetch cycle so the finished instruction's results are visible.
    task automatic run_instr(output int lat);
        int n = 1;
        while (!instr_done && n < 16) begin
            @(negedge clk);
            n++;
        end
        lat = instr_done ? n : 0;
        @(negedge clk);
    endtask

    task automatic wait_halt(output int lat);
        int n = 1;
        while (!halted && n < 16) begin
            @(negedge clk);
            n++;
        end
        lat = halted ? n : 0;
    endtask

    // ---------------- instruction-level reference model ----------------
    task automatic model_run(input int max_instr);
        logic [3:0] p, ea;
        logic [7:0] a, w, m;
        logic [8:0] s;
        logic       e;
        int         l;
        p = 4'd0; a = 8'd0; e = 1'b0; mdl_halt = 1'b0;
        exp_q.delete(); lat_q.delete();
        for (int i = 0; i < 16; i++) mdl_mem[i] = img[i];
        for (int k = 0; k < max_instr && !mdl_halt; k++) begin
            w = mdl_mem[p];
            p = p + 4'd1;
            if (w[6:4] == 3'd7 && w[7]) begin
                mdl_halt = 1'b1;
            end else begin
                if (w[6:4] == 3'd7) begin
                    p = w[3:0]; l = 3;
                end else if (w[6:4] == 3'd3) begin
                    s = {1'b0, a} + {1'b0, a}; e = s[8]; a = s[7:0]; l = 4;
                end else if (w[6:4] == 3'd6) begin
                    a = ~a; l = 4;
                end else begin
                    ea = w[7] ? mdl_mem[w[3:0]][3:0] : w[3:0];
                    l  = ((w[6:4] == 3'd5) ? 4 : 5) + (w[7] ? 2 : 0);
                    m  = mdl_mem[ea];
                    case (w[6:4])
                        3'd0: begin s = {1'b0, a} + {1'b0, m}; e = s[8]; a = s[7:0]; end
                        3'd1: begin e = (a < m); a = a - m; end
                        3'd2: a = a ^ m;
                        3'd4: a = m;
                        default: mdl_mem[ea] = a;
                    endcase
                end
                exp_q.push_back({p, e, (a == 8'd0), a});
                lat_q.push_back(l);
            end
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string      name;
        logic [7:0] instr, ac0, m15, m13, exp_ac;
        logic       exp_e, exp_z;
        int         exp_lat;
        logic [3:0] exp_pc;
    } vec_t;
    vec_t vecs[14];

    // ---------------- test ----------------
    initial begin
        int lat, n, we_cnt, we_n, frz;
        logic [7:0] we_a, we_d, a0;
        logic [3:0] p0;
        logic [13:0] exp;

        rst = 1'b1; rst2 = 1'b1; load_en = 1'b0; load_sel = 1'b0;
        load_addr = 8'd0; load_data = 12'd0;
        repeat (2) @(negedge clk);
        check("rst_pc", pc, 0);
        check("rst_ac", ac, 0);
        check("rst_z", z_flag, 1);
        check("rst_e", e_flag, 0);
        check("rst_halted", halted, 0);
        check("rst_we", mem_we, 0);
        check("rst_done", instr_done, 0);

        //            name     instr  ac0    m15    m13    ac     e  z  lat pc
        vecs[0]  = '{"add",    8'h0F, 8'h03, 8'h05, 8'h00, 8'h08, 0, 0, 5, 4'h2};
        vecs[1]  = '{"add_c",  8'h0F, 8'hF0, 8'h20, 8'h00, 8'h10, 1, 0, 5, 4'h2};
        vecs[2]  = '{"add_z",  8'h0F, 8'h80, 8'h80, 8'h00, 8'h00, 1, 1, 5, 4'h2};
        vecs[3]  = '{"sub_b",  8'h1F, 8'h03, 8'h05, 8'h00, 8'hFE, 1, 0, 5, 4'h2};
        vecs[4]  = '{"sub_eq", 8'h1F, 8'h05, 8'h05, 8'h00, 8'h00, 0, 1, 5, 4'h2};
        vecs[5]  = '{"xor",    8'h2F, 8'hA5, 8'hFF, 8'h00, 8'h5A, 0, 0, 5, 4'h2};
        vecs[6]  = '{"shl",    8'h30, 8'h81, 8'h00, 8'h00, 8'h02, 1, 0, 4, 4'h2};
        vecs[7]  = '{"shl_i",  8'hB0, 8'h40, 8'h00, 8'h00, 8'h80, 0, 0, 4, 4'h2};
        vecs[8]  = '{"cma",    8'h60, 8'hFF, 8'h00, 8'h00, 8'h00, 0, 1, 4, 4'h2};
        vecs[9]  = '{"lda",    8'h4F, 8'h77, 8'h00, 8'h00, 8'h00, 0, 1, 5, 4'h2};
        vecs[10] = '{"sta",    8'h5C, 8'h3C, 8'h00, 8'h00, 8'h3C, 0, 0, 4, 4'h2};
        vecs[11] = '{"jmp",    8'h7C, 8'h3C, 8'h00, 8'h00, 8'h3C, 0, 0, 3, 4'hC};
        vecs[12] = '{"add_i",  8'h8F, 8'h22, 8'h0D, 8'h11, 8'h33, 0, 0, 7, 4'h2};
        vecs[13] = '{"lda_i",  8'hCF, 8'h55, 8'h0D, 8'h00, 8'h00, 0, 1, 7, 4'h2};

        foreach (vecs[k]) begin
            clear_img();
            img[0] = 8'h4E; img[14] = vecs[k].ac0; img[1] = vecs[k].instr;
            img[15] = vecs[k].m15; img[13] = vecs[k].m13;
            start_prog();
            run_instr(lat);
            run_instr(lat);
            check($sformatf("%s_lat", vecs[k].name), lat, vecs[k].exp_lat);
            check($sformatf("%s_ac", vecs[k].name), ac, vecs[k].exp_ac);
            check($sformatf("%s_e", vecs[k].name), e_flag, vecs[k].exp_e);
            check($sformatf("%s_z", vecs[k].name), z_flag, vecs[k].exp_z);
            check($sformatf("%s_pc", vecs[k].name), pc, vecs[k].exp_pc);
        end
        check("sta_mem", mem[12], 8'h00);  // last row did not store

        // Direct load and add, then reset mid-instruction.
        clear_img();
        img[0] = 8'h48; img[1] = 8'h09; img[8] = 8'hF0; img[9] = 8'h20;
        start_prog();
        run_instr(lat); check("ldadd_lat1", lat, 5);
        run_instr(lat); check("ldadd_lat2", lat, 5);
        check("ldadd_ac", ac, 8'h10);
        check("ldadd_e", e_flag, 1);
        check("ldadd_z", z_flag, 0);
        check("ldadd_pc", pc, 2);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_pc", pc, 0);
        check("midrst_ac", ac, 0);
        check("midrst_z", z_flag, 1);
        check("midrst_e", e_flag, 0);
        check("midrst_halted", halted, 0);
        check("midrst_we", mem_we, 0);
        rst = 1'b0;
        check("midrst_addr", mem_addr, 0);
        run_instr(lat);
        check("midrst_rerun_ac", ac, 8'hF0);

        // Indirect store: one write at cycle 6 to the pointed-to address.
        clear_img();
        img[0] = 8'h45; img[5] = 8'h3C; img[1] = 8'hDA; img[10] = 8'h0C;
        start_prog();
        run_instr(lat);
        we_cnt = 0; we_n = 0; we_a = 8'h00; we_d = 8'h00;
        n = 1;
        while (n <= 8) begin
            if (mem_we) begin
                we_cnt++; we_n = n; we_a = {4'h0, mem_addr}; we_d = mem_wdata;
            end
            @(negedge clk);
            n++;
        end
        check("sti_we_count", we_cnt, 1);
        check("sti_we_cycle", we_n, 6);
        check("sti_we_addr", we_a, 8'h0C);
        check("sti_we_data", we_d, 8'h3C);
        check("sti_mem", mem[12], 8'h3C);

        start_prog();
        run_instr(lat);
        repeat (5) @(negedge clk);
        check("sti_rst_exec", instr_done, 1);
        rst = 1'b1;
        #1;
        check("sti_rst_we", mem_we, 0);
        @(negedge clk);
        check("sti_rst_mem", mem[12], 8'h00);
        check("sti_rst_pc", pc, 0);
        rst = 1'b0;

        // Chained subtract: borrow, then exact zero.
        clear_img();
        img[0] = 8'h4D; img[13] = 8'h03; img[1] = 8'h1E; img[14] = 8'h05;
        img[2] = 8'h1F; img[15] = 8'hFE;
        start_prog();
        run_instr(lat); run_instr(lat);
        check("sub1_ac", ac, 8'hFE); check("sub1_e", e_flag, 1); check("sub1_z", z_flag, 0);
        run_instr(lat);
        check("sub2_ac", ac, 8'h00); check("sub2_e", e_flag, 0); check("sub2_z", z_flag, 1);

        // PC wrap into HLT at address 15, frozen state, restart by reset.
        clear_img();
        img[0] = 8'h4E; img[14] = 8'h99; img[1] = 8'h7F; img[15] = 8'hF0;
        start_prog();
        run_instr(lat); run_instr(lat);
        check("wrap_jmp_pc", pc, 4'hF);
        repeat (2) @(negedge clk);
        check("wrap_pc", pc, 0);
        @(negedge clk);
        check("hlt_halted", halted, 1);
        p0 = pc; a0 = ac; frz = 0;
        repeat (20) begin
            @(negedge clk);
            if (pc !== p0 || ac !== a0 || mem_we !== 1'b0 || halted !== 1'b1) frz++;
        end
        check("hlt_frozen", frz, 0);
        check("hlt_ac", ac, 8'h99);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("hlt_rst_halted", halted, 0);
        check("hlt_rst_addr", mem_addr, 0);
        run_instr(lat);
        check("hlt_rst_lat", lat, 5);
        check("hlt_rst_ac", ac, 8'h99);
        check("hlt_rst_pc", pc, 1);

        // Wide instance: JMP 0xC8.
        rst2 = 1'b1;
        load_word(1'b1, 8'h00, 12'h7C8);
        load_word(1'b1, 8'hC8, 12'h7C8);
        rst2 = 1'b0;
        n = 1;
        while (!b_done && n < 16) begin
            @(negedge clk);
            n++;
        end
        check("wide_lat", b_done ? n : 0, 3);
        @(negedge clk);
        check("wide_pc", b_pc, 8'hC8);
        check("wide_addr", b_mem_addr, 8'hC8);
        check("wide_ac", b_ac, 0);
        check("wide_flags", {b_e, b_z, b_halted}, 3'b010);

        // Random programs against the instruction-level model.
        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < 16; i++) img[i] = 8'($urandom_range(0, 255));
            model_run(25);
            start_prog();
            while (exp_q.size() > 0) begin
                run_instr(lat);
                exp = exp_q.pop_front();
                check("rnd_lat", lat, lat_q.pop_front());
                check("rnd_state", {pc, e_flag, z_flag, ac}, exp);
            end
            if (mdl_halt) begin
                wait_halt(n);
                check("rnd_halt", n, 4);
            end
            for (int i = 0; i < 16; i++) check("rnd_mem", mem[i], mdl_mem[i]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
